// File: rtl/acs_pm_unit.sv
// Add-compare-select path-metric unit for a rate-1/2 Viterbi decoder.
// Holds one metric per trellis state and produces survivor decisions, reachability and the best state per symbol.
module acs_pm_unit #(
  parameter int unsigned  K    = 3,
  parameter logic [K-1:0] G0   = 3'b111,
  parameter logic [K-1:0] G1   = 3'b101,
  parameter int unsigned  BM_W = 2,
  parameter int unsigned  PM_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_start,
  input  logic [4*BM_W-1:0]         bm,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic [(1<<(K-1))-1:0]     dec_bits,
  output logic [(1<<(K-1))-1:0]     state_valid,
  output logic [K-2:0]              best_state,
  output logic [PM_W-1:0]           best_pm
);

  localparam int unsigned N_ST = 1 << (K - 1);
  localparam int unsigned SW   = K - 1;
  localparam int unsigned EW   = PM_W + 1;

  logic [PM_W-1:0] r_pm [N_ST];
  logic [N_ST-1:0] r_valid;
  logic [N_ST-1:0] r_dec_bits;
  logic [SW-1:0]   r_best_state;
  logic [PM_W-1:0] r_best_pm;
  logic            r_dec_valid;

  logic            w_accept;
  logic [PM_W-1:0] w_src_pm [N_ST];
  logic [N_ST-1:0] w_src_valid;
  logic [PM_W-1:0] w_min;
  logic [PM_W-1:0] w_new_pm [N_ST];
  logic [N_ST-1:0] w_new_valid;
  logic [N_ST-1:0] w_new_dec;
  logic [SW-1:0]   w_best_state;
  logic [PM_W-1:0] w_best_pm;
  logic            w_best_found;

  // Single-entry output register: a new symbol may enter whenever the word drains this cycle.
  assign in_ready = !r_dec_valid || dec_ready;
  assign w_accept = in_valid && in_ready;

  // A block start restarts the trellis from state 0 with zero metrics.
  always_comb begin
    w_src_valid = in_start ? N_ST'(1) : r_valid;
    for (int s = 0; s < N_ST; s++) begin
      w_src_pm[s] = in_start ? '0 : r_pm[s];
    end
  end

  // Normalisation offset: smallest metric among reachable states only.
  always_comb begin
    w_min = '1;
    for (int s = 0; s < N_ST; s++) begin
      if (w_src_valid[s] && (w_src_pm[s] < w_min)) begin
        w_min = w_src_pm[s];
      end
    end
  end

  for (genvar s = 0; s < N_ST; s++) begin : g_acs
    localparam int unsigned    P0   = (2 * s) % N_ST;
    localparam int unsigned    P1   = P0 + 1;
    localparam int unsigned    U    = s / (N_ST / 2);
    localparam logic [K-1:0]   REG0 = K'(U * N_ST + P0);
    localparam logic [K-1:0]   REG1 = K'(U * N_ST + P1);
    localparam int unsigned    IDX0 = 2 * int'(^(REG0 & G0)) + int'(^(REG0 & G1));
    localparam int unsigned    IDX1 = 2 * int'(^(REG1 & G0)) + int'(^(REG1 & G1));

    logic [BM_W-1:0] w_bm0;
    logic [BM_W-1:0] w_bm1;
    logic [EW-1:0]   w_cand0;
    logic [EW-1:0]   w_cand1;
    logic [PM_W-1:0] w_sat0;
    logic [PM_W-1:0] w_sat1;
    logic            w_v0;
    logic            w_v1;
    logic            w_sel;

    assign w_bm0   = bm[IDX0*BM_W +: BM_W];
    assign w_bm1   = bm[IDX1*BM_W +: BM_W];
    assign w_cand0 = EW'(w_src_pm[P0]) - EW'(w_min) + EW'(w_bm0);
    assign w_cand1 = EW'(w_src_pm[P1]) - EW'(w_min) + EW'(w_bm1);
    // Carry into the extra bit means the metric overflowed; clamp to full scale.
    assign w_sat0  = w_cand0[PM_W] ? '1 : w_cand0[PM_W-1:0];
    assign w_sat1  = w_cand1[PM_W] ? '1 : w_cand1[PM_W-1:0];
    assign w_v0    = w_src_valid[P0];
    assign w_v1    = w_src_valid[P1];
    // Odd predecessor wins only when it alone is reachable or strictly cheaper.
    assign w_sel   = w_v1 && (!w_v0 || (w_sat1 < w_sat0));

    assign w_new_dec[s]   = w_sel;
    assign w_new_valid[s] = w_v0 || w_v1;
    assign w_new_pm[s]    = w_sel ? w_sat1 : w_sat0;
  end

  // Best state: lowest metric among reachable states, lowest index on ties.
  always_comb begin
    w_best_state = '0;
    w_best_pm    = '0;
    w_best_found = 1'b0;
    for (int s = 0; s < N_ST; s++) begin
      if (w_new_valid[s] && (!w_best_found || (w_new_pm[s] < w_best_pm))) begin
        w_best_found = 1'b1;
        w_best_state = SW'(s);
        w_best_pm    = w_new_pm[s];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < N_ST; s++) begin
        r_pm[s] <= '0;
      end
      r_valid      <= N_ST'(1);
      r_dec_bits   <= '0;
      r_best_state <= '0;
      r_best_pm    <= '0;
      r_dec_valid  <= 1'b0;
    end else if (w_accept) begin
      for (int s = 0; s < N_ST; s++) begin
        r_pm[s] <= w_new_pm[s];
      end
      r_valid      <= w_new_valid;
      r_dec_bits   <= w_new_dec;
      r_best_state <= w_best_state;
      r_best_pm    <= w_best_pm;
      r_dec_valid  <= 1'b1;
    end else if (dec_ready) begin
      r_dec_valid  <= 1'b0;
    end
  end

  assign dec_valid   = r_dec_valid;
  assign dec_bits    = r_dec_bits;
  assign state_valid = r_valid;
  assign best_state  = r_best_state;
  assign best_pm     = r_best_pm;

endmodule

// File: tb/tb_acs_pm_unit.sv
// Directed and model-based checks of acs_pm_unit at PM_W=8 and a saturating PM_W=3 copy.
module tb_acs_pm_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_start;
  logic [7:0] bm;
  logic       dec_ready;

  logic       in_ready_a, dec_valid_a;
  logic [3:0] dec_bits_a, state_valid_a;
  logic [1:0] best_state_a;
  logic [7:0] best_pm_a;

  logic       in_ready_b, dec_valid_b;
  logic [3:0] dec_bits_b, state_valid_b;
  logic [1:0] best_state_b;
  logic [2:0] best_pm_b;

  int n_checks = 0;
  int n_fail   = 0;

  int         m_pm     [2][4];
  logic [3:0] m_valid  [2];
  logic [3:0] m_dec    [2];
  int         m_best   [2];
  int         m_bestpm [2];

  always #5 clk = ~clk;

  acs_pm_unit #(.K(3), .G0(3'b111), .G1(3'b101), .BM_W(2), .PM_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_start(in_start),
    .bm(bm), .dec_valid(dec_valid_a), .dec_ready(dec_ready), .dec_bits(dec_bits_a),
    .state_valid(state_valid_a), .best_state(best_state_a), .best_pm(best_pm_a)
  );

  acs_pm_unit #(.K(3), .G0(3'b111), .G1(3'b101), .BM_W(2), .PM_W(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_start(in_start),
    .bm(bm), .dec_valid(dec_valid_b), .dec_ready(dec_ready), .dec_bits(dec_bits_b),
    .state_valid(state_valid_b), .best_state(best_state_b), .best_pm(best_pm_b)
  );

  // Forward trellis walk: every reachable state pushes both inputs into its successor.
  task automatic model_step(input int k, input int pmmax, input logic start, input logic [7:0] bmv);
    int spm [4];
    int npm [4];
    logic [3:0] sv, nv, nd;
    int mn, ns, r, c0, c1, cost, cand;
    logic found;
    sv = start ? 4'b0001 : m_valid[k];
    for (int p = 0; p < 4; p++) spm[p] = start ? 0 : m_pm[k][p];
    mn = 1 << 30;
    for (int p = 0; p < 4; p++) if (sv[p] && spm[p] < mn) mn = spm[p];
    nv = 4'b0000;
    nd = 4'b0000;
    for (int p = 0; p < 4; p++) npm[p] = 0;
    for (int p = 0; p < 4; p++) begin
      if (sv[p]) begin
        for (int u = 0; u < 2; u++) begin
          ns   = u * 2 + p / 2;
          r    = u * 4 + p;
          c0   = (r ^ (r >> 1) ^ (r >> 2)) & 1;
          c1   = (r ^ (r >> 2)) & 1;
          cost = int'(bmv >> ((c0 * 2 + c1) * 2)) & 3;
          cand = spm[p] - mn + cost;
          if (cand > pmmax) cand = pmmax;
          if (!nv[ns] || cand < npm[ns]) begin
            npm[ns] = cand;
            nd[ns]  = (p % 2 == 1);
            nv[ns]  = 1'b1;
          end
        end
      end
    end
    found = 1'b0;
    m_best[k]   = 0;
    m_bestpm[k] = 0;
    for (int s = 0; s < 4; s++) begin
      m_pm[k][s] = npm[s];
      if (nv[s] && (!found || npm[s] < m_bestpm[k])) begin
        found       = 1'b1;
        m_best[k]   = s;
        m_bestpm[k] = npm[s];
      end
    end
    m_valid[k] = nv;
    m_dec[k]   = nd;
  endtask

  task automatic send(input logic start, input logic [7:0] bmv);
    in_valid = 1'b1;
    in_start = start;
    bm       = bmv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_start = 1'b0; bm = 8'h00; dec_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks += 6;
    if (dec_valid_a !== 1'b0)      begin n_fail++; $display("FAIL reset_dec_valid got %b exp 0", dec_valid_a); end
    if (in_ready_a !== 1'b1)       begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready_a); end
    if (state_valid_a !== 4'b0001) begin n_fail++; $display("FAIL reset_state_valid got %b exp 0001", state_valid_a); end
    if (dec_bits_a !== 4'b0000)    begin n_fail++; $display("FAIL reset_dec_bits got %b exp 0000", dec_bits_a); end
    if (best_state_a !== 2'd0)     begin n_fail++; $display("FAIL reset_best_state got %0d exp 0", best_state_a); end
    if (best_pm_a !== 8'd0)        begin n_fail++; $display("FAIL reset_best_pm got %0d exp 0", best_pm_a); end
  endtask

  task automatic test_first_symbol(input string tag);
    send(1'b1, 8'b10_10_10_00);
    n_checks += 5;
    if (state_valid_a !== 4'b0101) begin n_fail++; $display("FAIL %s_state_valid got %b exp 0101", tag, state_valid_a); end
    if (dec_bits_a !== 4'b0000)    begin n_fail++; $display("FAIL %s_dec_bits got %b exp 0000", tag, dec_bits_a); end
    if (best_state_a !== 2'd0)     begin n_fail++; $display("FAIL %s_best_state got %0d exp 0", tag, best_state_a); end
    if (best_pm_a !== 8'd0)        begin n_fail++; $display("FAIL %s_best_pm got %0d exp 0", tag, best_pm_a); end
    if (dec_valid_a !== 1'b1)      begin n_fail++; $display("FAIL %s_dec_valid got %b exp 1", tag, dec_valid_a); end
  endtask

  task automatic test_second_symbol();
    send(1'b0, 8'b00_10_10_10);
    n_checks += 4;
    if (state_valid_a !== 4'b1111) begin n_fail++; $display("FAIL sym2_state_valid got %b exp 1111", state_valid_a); end
    if (dec_bits_a !== 4'b0000)    begin n_fail++; $display("FAIL sym2_dec_bits got %b exp 0000", dec_bits_a); end
    if (best_state_a !== 2'd2)     begin n_fail++; $display("FAIL sym2_best_state got %0d exp 2", best_state_a); end
    if (best_pm_a !== 8'd0)        begin n_fail++; $display("FAIL sym2_best_pm got %0d exp 0", best_pm_a); end
  endtask

  task automatic test_backpressure();
    dec_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_start = 1'b1;
      bm       = 8'hFF;
      #1;
      n_checks += 1;
      if (in_ready_a !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d] got %b exp 0", i, in_ready_a); end
      @(posedge clk);
      #1;
      n_checks += 5;
      if (dec_valid_a !== 1'b1)      begin n_fail++; $display("FAIL hold_dec_valid[%0d] got %b exp 1", i, dec_valid_a); end
      if (state_valid_a !== 4'b1111) begin n_fail++; $display("FAIL hold_state_valid[%0d] got %b exp 1111", i, state_valid_a); end
      if (dec_bits_a !== 4'b0000)    begin n_fail++; $display("FAIL hold_dec_bits[%0d] got %b exp 0000", i, dec_bits_a); end
      if (best_state_a !== 2'd2)     begin n_fail++; $display("FAIL hold_best_state[%0d] got %0d exp 2", i, best_state_a); end
      if (best_pm_a !== 8'd0)        begin n_fail++; $display("FAIL hold_best_pm[%0d] got %0d exp 0", i, best_pm_a); end
    end
    dec_ready = 1'b1;
    in_start  = 1'b0;
    bm        = 8'b00_10_00_10;
    #1;
    n_checks += 1;
    if (in_ready_a !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b exp 1", in_ready_a); end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks += 5;
    if (dec_valid_a !== 1'b1)      begin n_fail++; $display("FAIL release_dec_valid got %b exp 1", dec_valid_a); end
    if (state_valid_a !== 4'b1111) begin n_fail++; $display("FAIL release_state_valid got %b exp 1111", state_valid_a); end
    if (dec_bits_a !== 4'b0000)    begin n_fail++; $display("FAIL release_dec_bits got %b exp 0000", dec_bits_a); end
    if (best_state_a !== 2'd3)     begin n_fail++; $display("FAIL release_best_state got %0d exp 3", best_state_a); end
    if (best_pm_a !== 8'd0)        begin n_fail++; $display("FAIL release_best_pm got %0d exp 0", best_pm_a); end
  endtask

  task automatic test_select_and_tie();
    logic [3:0] exp_dec [3];
    logic [1:0] exp_best [3];
    exp_dec[0] = 4'b1111; exp_best[0] = 2'd1;
    exp_dec[1] = 4'b1111; exp_best[1] = 2'd0;
    exp_dec[2] = 4'b0000; exp_best[2] = 2'd0;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 8'h00);
      n_checks += 3;
      if (dec_bits_a !== exp_dec[i])    begin n_fail++; $display("FAIL select_dec_bits[%0d] got %b exp %b", i, dec_bits_a, exp_dec[i]); end
      if (best_state_a !== exp_best[i]) begin n_fail++; $display("FAIL select_best_state[%0d] got %0d exp %0d", i, best_state_a, exp_best[i]); end
      if (best_pm_a !== 8'd0)           begin n_fail++; $display("FAIL select_best_pm[%0d] got %0d exp 0", i, best_pm_a); end
    end
  endtask

  task automatic test_drain();
    @(posedge clk);
    #1;
    n_checks += 2;
    if (dec_valid_a !== 1'b0)      begin n_fail++; $display("FAIL drain_dec_valid got %b exp 0", dec_valid_a); end
    if (state_valid_a !== 4'b1111) begin n_fail++; $display("FAIL drain_state_valid got %b exp 1111", state_valid_a); end
  endtask

  task automatic test_back_to_back_random();
    logic [7:0] bmv;
    dec_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bmv = 8'($urandom_range(0, 255));
      send(i == 0, bmv);
      model_step(0, 255, i == 0, bmv);
      model_step(1, 7, i == 0, bmv);
      n_checks += 10;
      if (dec_valid_a !== 1'b1)                 begin n_fail++; $display("FAIL rnd_a_dec_valid[%0d] got %b exp 1", i, dec_valid_a); end
      if (dec_bits_a !== m_dec[0])              begin n_fail++; $display("FAIL rnd_a_dec_bits[%0d] got %b exp %b", i, dec_bits_a, m_dec[0]); end
      if (state_valid_a !== m_valid[0])         begin n_fail++; $display("FAIL rnd_a_state_valid[%0d] got %b exp %b", i, state_valid_a, m_valid[0]); end
      if (best_state_a !== 2'(m_best[0]))       begin n_fail++; $display("FAIL rnd_a_best_state[%0d] got %0d exp %0d", i, best_state_a, m_best[0]); end
      if (best_pm_a !== 8'(m_bestpm[0]))        begin n_fail++; $display("FAIL rnd_a_best_pm[%0d] got %0d exp %0d", i, best_pm_a, m_bestpm[0]); end
      if (dec_valid_b !== 1'b1)                 begin n_fail++; $display("FAIL rnd_b_dec_valid[%0d] got %b exp 1", i, dec_valid_b); end
      if (dec_bits_b !== m_dec[1])              begin n_fail++; $display("FAIL rnd_b_dec_bits[%0d] got %b exp %b", i, dec_bits_b, m_dec[1]); end
      if (state_valid_b !== m_valid[1])         begin n_fail++; $display("FAIL rnd_b_state_valid[%0d] got %b exp %b", i, state_valid_b, m_valid[1]); end
      if (best_state_b !== 2'(m_best[1]))       begin n_fail++; $display("FAIL rnd_b_best_state[%0d] got %0d exp %0d", i, best_state_b, m_best[1]); end
      if (best_pm_b !== 3'(m_bestpm[1]))        begin n_fail++; $display("FAIL rnd_b_best_pm[%0d] got %0d exp %0d", i, best_pm_b, m_bestpm[1]); end
    end
  endtask

  task automatic test_reset_mid();
    send(1'b0, 8'h5A);
    dec_ready = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    bm        = 8'h33;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    dec_ready = 1'b1;
    n_checks += 5;
    if (dec_valid_a !== 1'b0)      begin n_fail++; $display("FAIL midrst_dec_valid got %b exp 0", dec_valid_a); end
    if (state_valid_a !== 4'b0001) begin n_fail++; $display("FAIL midrst_state_valid got %b exp 0001", state_valid_a); end
    if (dec_bits_a !== 4'b0000)    begin n_fail++; $display("FAIL midrst_dec_bits got %b exp 0000", dec_bits_a); end
    if (best_pm_a !== 8'd0)        begin n_fail++; $display("FAIL midrst_best_pm got %0d exp 0", best_pm_a); end
    if (in_ready_a !== 1'b1)       begin n_fail++; $display("FAIL midrst_in_ready got %b exp 1", in_ready_a); end
  endtask

  task automatic test_restart();
    send(1'b0, 8'hC6);
    send(1'b0, 8'h1B);
    send(1'b0, 8'hE4);
    test_first_symbol("restart");
  endtask

  initial begin
    test_reset();
    test_first_symbol("sym1");
    test_second_symbol();
    test_backpressure();
    test_select_and_tie();
    test_drain();
    test_back_to_back_random();
    test_reset_mid();
    test_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
